// File: rtl/shift_ctrl_pkg.sv
// Shared widths, state encoding and request payload for the shift-register sequencer.
package shift_ctrl_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned Q_W     = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
    } op_t;

endpackage

// File: rtl/shift_ctrl_if.sv
// Upstream, shift-register and downstream signals of the shift sequencer.
interface shift_ctrl_if;
    import shift_ctrl_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHAMT_W-1:0] in_shamt;

    logic               sr_load;
    logic               sr_shiftrighten;
    logic [DATA_W-1:0]  sr_data;
    logic [Q_W-1:0]     sr_q;

    logic               out_valid;
    logic               out_ready;
    logic [Q_W-1:0]     out_data;
    logic               busy;

    // Controller side.
    modport master (
        input  in_valid, in_data, in_shamt, sr_q, out_ready,
        output in_ready, sr_load, sr_shiftrighten, sr_data, out_valid, out_data, busy
    );

    // Environment side: upstream source, shift register and downstream sink.
    modport slave (
        output in_valid, in_data, in_shamt, sr_q, out_ready,
        input  in_ready, sr_load, sr_shiftrighten, sr_data, out_valid, out_data, busy
    );

endinterface

// File: rtl/shift_ctrl_cnt.sv
// Loadable down-counter tracking the shift pulses still to issue.
module shift_ctrl_cnt
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned W = SHAMT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_zero_c,
    output logic         is_one_c
);

    logic [W-1:0] cnt;

    // Clear wins over load; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign is_zero_c = (cnt == '0);
    assign is_one_c  = (cnt == W'(1));

endmodule

// File: rtl/shift_ctrl.sv
// Sequencer for the 32-bit right-shift register: load, shift N times, return result.
// Optional abort input enabled by defining SHIFT_CTRL_ABORT_EN.
module shift_ctrl
    import shift_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
`ifdef SHIFT_CTRL_ABORT_EN
    input  logic         abort,
`endif
    shift_ctrl_if.master bus
);

    state_e            state;
    state_e            state_d;
    op_t               req_c;
    logic [DATA_W-1:0] op_reg;

    logic in_ready_q;
    logic sr_load_q;
    logic sr_shift_q;
    logic out_valid_q;
    logic busy_q;

    logic accept_c;
    logic abort_c;
    logic cnt_load_c;
    logic cnt_dec_c;
    logic cnt_zero_c;
    logic cnt_one_c;

    assign req_c = '{data: bus.in_data, shamt: bus.in_shamt};

`ifdef SHIFT_CTRL_ABORT_EN
    // Abort only matters while an operation is in flight.
    assign abort_c = abort && (state != IDLE);
`else
    assign abort_c = 1'b0;
`endif

    shift_ctrl_cnt #(
        .W (SHAMT_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort_c),
        .load      (cnt_load_c),
        .load_val  (req_c.shamt),
        .dec       (cnt_dec_c),
        .is_zero_c (cnt_zero_c),
        .is_one_c  (cnt_one_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        accept_c   = 1'b0;
        cnt_load_c = 1'b0;
        cnt_dec_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept_c   = 1'b1;
                    cnt_load_c = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                state_d = cnt_zero_c ? DONE : SHIFT;
            end
            SHIFT: begin
                cnt_dec_c = 1'b1;
                if (cnt_one_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_c) begin
            state_d = IDLE;
        end
    end

    // Strobes and flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q  <= 1'b1;
            sr_load_q   <= 1'b0;
            sr_shift_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_reg      <= '0;
        end else begin
            in_ready_q  <= (state_d == IDLE);
            sr_load_q   <= (state_d == LOAD);
            sr_shift_q  <= (state_d == SHIFT);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
            if (accept_c) begin
                op_reg <= req_c.data;
            end
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.sr_load         = sr_load_q;
    assign bus.sr_shiftrighten = sr_shift_q;
    assign bus.sr_data         = op_reg;
    assign bus.out_valid       = out_valid_q;
    assign bus.busy            = busy_q;

    // The register settles on the edge entering DONE, so the result is passed straight through.
    assign bus.out_data = out_valid_q ? bus.sr_q : Q_W'(0);

endmodule

// File: tb/tb_shift_ctrl.sv
// Randomized self-checking bench for shift_ctrl with a shift-register model on its strobes.
module tb_shift_ctrl;
    import shift_ctrl_pkg::*;

    logic clk;
    logic rst;
`ifdef SHIFT_CTRL_ABORT_EN
    logic abort;
`endif

    int n_vec;
    int n_err;

    shift_ctrl_if bus ();

    shift_ctrl dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SHIFT_CTRL_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The 32-bit right-shift register being sequenced; loads into the upper half.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.sr_q <= '0;
        end else if (bus.sr_load) begin
            bus.sr_q <= {bus.sr_data, 16'h0000};
        end else if (bus.sr_shiftrighten) begin
            bus.sr_q <= bus.sr_q >> 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Offer one operand in IDLE; returns at the negedge after the accepting edge.
    task automatic accept(input logic [DATA_W-1:0] d, input logic [SHAMT_W-1:0] s);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        chk("acc_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        bus.in_shamt = 5'($urandom);
    endtask

    // Follow an accepted operation to completion and compare with the expected result.
    task automatic observe(input logic [DATA_W-1:0] d, input logic [SHAMT_W-1:0] s,
                           input int hold, input bit inject,
                           input logic [DATA_W-1:0] nd, input logic [SHAMT_W-1:0] ns);
        logic [31:0] exp;
        int cyc;
        int loads;
        int shifts;
        int bad;
        exp    = {d, 16'h0000} >> s;
        cyc    = 0;
        loads  = 0;
        shifts = 0;
        bad    = 0;
        chk("sr_data", 32'(bus.sr_data), 32'(d));
        while (!bus.out_valid && cyc < 80) begin
            if (bus.sr_load) loads++;
            if (bus.sr_shiftrighten) shifts++;
            if (bus.sr_load && bus.sr_shiftrighten) bad++;
            if (bus.out_data != 32'h0) bad++;
            if (bus.in_ready || !bus.busy) bad++;
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(1 + int'(s)));
        chk("loads", 32'(loads), 32'd1);
        chk("shifts", 32'(shifts), 32'(s));
        chk("busy_flags", 32'(bad), 32'd0);
        chk("out_data", bus.out_data, exp);
        if (hold > 0) begin
            bad = 0;
            bus.out_ready = 1'b0;
            if (inject) begin
                bus.in_valid = 1'b1;
                bus.in_data  = nd;
                bus.in_shamt = ns;
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.out_data != exp || !bus.out_valid || bus.in_ready) bad++;
                if (bus.sr_load || bus.sr_shiftrighten) bad++;
            end
            chk("hold", 32'(bad), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("to_idle", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
        bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [DATA_W-1:0] d, input logic [SHAMT_W-1:0] s);
        accept(d, s);
        observe(d, s, 0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0]  d;
        logic [SHAMT_W-1:0] s;
        logic [DATA_W-1:0]  nd;
        logic [SHAMT_W-1:0] ns;
        int hold;
        bit inject;
        bit pending;

        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
`ifdef SHIFT_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_flags", 32'({bus.in_ready, bus.busy, bus.out_valid, bus.sr_load, bus.sr_shiftrighten}), 32'b10000);
        chk("rst_data", 32'({bus.sr_data, bus.out_data[15:0]}), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a shift sequence.
        accept(16'hABCD, 5'd10);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_q", bus.sr_q, 32'h0ABCD000);
        #2 rst = 1'b0;
        #1;
        chk("async_flags", 32'({bus.in_ready, bus.busy, bus.out_valid, bus.sr_load, bus.sr_shiftrighten}), 32'b10000);
        chk("async_sr_data", 32'(bus.sr_data), 32'h0);
        chk("async_out", bus.out_data, 32'h0);
        chk("async_q", bus.sr_q, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(16'h1234, 5'd3);

        // Directed corner cases.
        run_op(16'h8001, 5'd4);
        run_op(16'hFFFF, 5'd0);
        run_op(16'h8000, 5'd31);

        // Back-pressure with a competing offer, then back-to-back accept.
        accept(16'h00F0, 5'd2);
        observe(16'h00F0, 5'd2, 6, 1'b1, 16'hC3A5, 5'd7);
        run_op(16'hC3A5, 5'd7);

`ifdef SHIFT_CTRL_ABORT_EN
        // Abort on the second SHIFT cycle.
        accept(16'h5A5A, 5'd8);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_abort_shift", 32'(bus.sr_shiftrighten), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 32'({bus.in_ready, bus.busy, bus.out_valid, bus.sr_shiftrighten}), 32'b1000);
        begin
            int seen;
            seen = 0;
            repeat (10) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            chk("abort_no_result", 32'(seen), 32'd0);
        end
        run_op(16'h9999, 5'd5);

        // Abort while idle must not block an accept.
        abort = 1'b1;
        accept(16'h0F0F, 5'd6);
        abort = 1'b0;
        observe(16'h0F0F, 5'd6, 0, 1'b0, '0, '0);
`endif

        // Randomized operations with random hold and competing offers.
        pending = 1'b0;
        d = '0;
        s = '0;
        for (int i = 0; i < 24; i++) begin
            if (!pending) begin
                d = 16'($urandom);
                s = 5'($urandom_range(0, 31));
            end
            hold   = int'($urandom_range(0, 3));
            inject = (hold > 0) && (i != 23) && ($urandom_range(0, 1) == 1);
            nd     = 16'($urandom);
            ns     = 5'($urandom_range(0, 31));
            accept(d, s);
            observe(d, s, hold, inject, nd, ns);
            pending = inject;
            d = nd;
            s = ns;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
Sequencer directly upstream of the 32-bit right-shift register. Accepts a 16-bit operand plus a shift amount over a valid/ready handshake. Drives the register's load and shift-right-enable strobes for the required number of cycles, then returns the register's 32-bit contents downstream over a second valid/ready handshake. One operation is in flight at a time.

Parameters:
DATA_W, 16, operand width; drives the register's 16-bit data input.
Q_W, 32, register width; must equal 2*DATA_W.
SHAMT_W, 5, shift-amount width; legal shift amounts are 0..2**SHAMT_W-1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  an operand is offered.
in_ready  output  1  controller can accept an operand; high only in IDLE.
in_data  input  DATA_W  operand.
in_shamt  input  SHAMT_W  number of right shifts to apply.
sr_load  output  1  load strobe to the shift register.
sr_shiftrighten  output  1  shift-right strobe to the shift register.
sr_data  output  DATA_W  operand to the shift register; the captured operand, held stable.
sr_q  input  Q_W  current shift register contents.
out_valid  output  1  result available; high only in DONE.
out_ready  input  1  downstream accepts the result.
out_data  output  Q_W  equals sr_q in DONE; 0 in all other states.
busy  output  1  high in LOAD, SHIFT and DONE.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. Internal registers: state, op_reg (DATA_W), cnt (SHAMT_W).
- Reset (rst low, any time, including mid-operation):
  - State goes to IDLE; op_reg and cnt clear to 0.
  - sr_load = 0, sr_shiftrighten = 0, sr_data = 0, out_valid = 0, out_data = 0, busy = 0.
  - in_ready = 1, because it is a decode of IDLE.
  - The shift register shares the reset net, so it also clears.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture in_data into op_reg and in_shamt into cnt; go to LOAD.
- LOAD (exactly 1 cycle):
  - sr_load = 1, sr_data = op_reg.
  - Next state is SHIFT if cnt != 0, otherwise DONE.
- SHIFT:
  - sr_shiftrighten = 1 every cycle; cnt decrements each cycle.
  - When cnt == 1 at the edge, go to DONE.
  - Exactly in_shamt shift pulses are issued in total.
- DONE:
  - out_valid = 1, out_data = sr_q. sr_q is stable because both strobes are low.
  - Hold until out_ready; on out_valid && out_ready go to IDLE.
  - out_ready is ignored in every other state.
- sr_load and sr_shiftrighten are never asserted in the same cycle.
- Latency: if the handshake completes at edge E, out_valid rises 1 + in_shamt cycles after E.
- Throughput: one operation per 3 + in_shamt cycles (accept, LOAD, in_shamt SHIFT cycles, DONE with immediate out_ready). A new accept is possible the cycle after DONE.
- in_valid while not in IDLE is not accepted; the upstream source must hold its data.
- Maximum shift is 2**SHAMT_W-1 (31): the operand ends at bit 0 with 31 zeros above.
- cnt never wraps below 0; a decrement is impossible outside SHIFT.

Optional Feature:
Macro SHIFT_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort high in LOAD, SHIFT or DONE forces IDLE at the next edge, no result is produced, and cnt clears.
  - abort is ignored in IDLE.
  - abort takes priority over the out_ready handshake.
  - The shift register keeps its partial value, and the next LOAD overwrites it.
- Undefined: no abort port exists; behaviour is exactly as above.

Decomposition:
- Package shift_ctrl_pkg holds:
  - the state encoding constants (IDLE = 0, LOAD = 1, SHIFT = 2, DONE = 3, 2-bit);
  - the default widths DATA_W, Q_W and SHAMT_W.
- One sub-module is natural: shift_ctrl_cnt, a loadable SHAMT_W down-counter with load, dec and is_one outputs, instantiated once.
- The FSM and output decode stay in shift_ctrl.

Test Plan:
1. Reset during SHIFT: in_data = 16'hABCD, in_shamt = 10; drop rst after 4 shifts -> all outputs 0 and in_ready = 1 immediately, asynchronously; next operation runs cleanly.
2. Basic operation: in_data = 16'h8001, in_shamt = 4, out_ready = 1 -> 1 sr_load cycle, 4 sr_shiftrighten cycles, out_data = 32'h08001000, out_valid rises 5 cycles after accept.
3. Zero shift: in_data = 16'hFFFF, in_shamt = 0 -> LOAD then DONE, no shift pulses, out_data = 32'hFFFF0000.
4. Maximum shift: in_data = 16'h8000, in_shamt = 31 -> exactly 31 shift pulses, out_data = 32'h00000001.
5. Back-pressure: hold out_ready = 0 for 6 cycles in DONE -> out_data stable, no strobes, in_ready = 0, and a new in_valid during this time is not accepted; assert out_ready -> IDLE next edge, then back-to-back accept.
6. SHIFT_CTRL_ABORT_EN defined: abort at the 2nd SHIFT cycle of an in_shamt = 8 operation -> IDLE next edge, out_valid never asserted, the following operation is correct.
